// File: rtl/ram_port_ctrl_pkg.sv
// Shared types and default sizing for the row-select RAM port controller.
package ram_port_ctrl_pkg;

    localparam int DEF_DATA_W = 11;
    localparam int DEF_ROWS   = 16;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [2:0] {
        LOAD,
        LWR,
        IDLE,
        RD,
        WR
    } state_e;

endpackage

// File: rtl/ram_port_ctrl_row_decoder.sv
// Row decoder: binary address plus enable to a one-hot row select.
// Addresses at or beyond ROWS decode to an all-zero vector.
module ram_port_ctrl_row_decoder
    import ram_port_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ROWS   = DEF_ROWS
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [ROWS-1:0]   sel
);

    always_comb begin
        sel = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (en && (addr == ADDR_W'(i))) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_ctrl.sv
// Sequencing controller for the row-select RAM: boot-loads rows, then serves CPU
// read/write requests. Boot loading is compiled in by RAM_PORT_CTRL_BOOTLOAD_EN.
module ram_port_ctrl
    import ram_port_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_done,
    output logic [DATA_W-1:0] ram_write_data,
    output logic [ROWS-1:0]   ram_write_select,
    output logic [ROWS-1:0]   ram_read_select_1,
    output logic [ROWS-1:0]   ram_read_select_2,
    input  logic [DATA_W-1:0] ram_read_data_1,
    input  logic [DATA_W-1:0] ram_read_data_2
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_a_q, rsp_data_a_d;
    logic [DATA_W-1:0] rsp_data_b_q, rsp_data_b_d;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

`ifdef RAM_PORT_CTRL_BOOTLOAD_EN
    localparam state_e RESET_STATE = LOAD;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic              load_last_q, load_last_d;
    logic              load_done_q, load_done_d;

    assign load_ready = (state_q == LOAD);
    assign load_done  = load_done_q;
    assign wr_en      = (state_q == WR) || (state_q == LWR);
    assign wr_addr    = (state_q == LWR) ? load_cnt_q : addr_a_q;
`else
    localparam state_e RESET_STATE = IDLE;
    logic unused_load;

    assign unused_load = ^{load_valid, load_last, load_data};
    assign load_ready  = 1'b0;
    assign load_done   = 1'b1;
    assign wr_en       = (state_q == WR);
    assign wr_addr     = addr_a_q;
`endif

    assign req_ready      = (state_q == IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data_a     = rsp_data_a_q;
    assign rsp_data_b     = rsp_data_b_q;
    assign ram_write_data = wdata_q;

    // Selects decode from registered state, so reset clears them without waiting for a clock.
    ram_port_ctrl_row_decoder #(.ADDR_W(ADDR_W), .ROWS(ROWS)) u_dec_wr (
        .addr(wr_addr), .en(wr_en), .sel(ram_write_select)
    );
    ram_port_ctrl_row_decoder #(.ADDR_W(ADDR_W), .ROWS(ROWS)) u_dec_rd1 (
        .addr(addr_a_q), .en(state_q == RD), .sel(ram_read_select_1)
    );
    ram_port_ctrl_row_decoder #(.ADDR_W(ADDR_W), .ROWS(ROWS)) u_dec_rd2 (
        .addr(addr_b_q), .en(state_q == RD), .sel(ram_read_select_2)
    );

    always_comb begin
        state_d      = state_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_data_a_d = rsp_data_a_q;
        rsp_data_b_d = rsp_data_b_q;
`ifdef RAM_PORT_CTRL_BOOTLOAD_EN
        load_cnt_d   = load_cnt_q;
        load_last_d  = load_last_q;
        load_done_d  = load_done_q;
`endif
        case (state_q)
`ifdef RAM_PORT_CTRL_BOOTLOAD_EN
            LOAD: begin
                if (load_valid) begin
                    wdata_d     = load_data;
                    load_last_d = load_last;
                    state_d     = LWR;
                end
            end
            LWR: begin
                if (load_last_q || (load_cnt_q == ADDR_W'(ROWS - 1))) begin
                    load_done_d = 1'b1;
                    load_cnt_d  = '0;
                    state_d     = IDLE;
                end else begin
                    load_cnt_d  = load_cnt_q + ADDR_W'(1);
                    state_d     = LOAD;
                end
            end
`endif
            IDLE: begin
                if (req_valid) begin
                    addr_a_d = req_addr_a;
                    addr_b_d = req_addr_b;
                    if (req_write) begin
                        wdata_d = req_wdata;
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                // An out-of-range port has no select, so its data bus is meaningless: force 0.
                rsp_valid_d  = 1'b1;
                rsp_data_a_d = (|ram_read_select_1) ? ram_read_data_1 : '0;
                rsp_data_b_d = (|ram_read_select_2) ? ram_read_data_2 : '0;
                state_d      = IDLE;
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RESET_STATE;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            wdata_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_a_q <= '0;
            rsp_data_b_q <= '0;
`ifdef RAM_PORT_CTRL_BOOTLOAD_EN
            load_cnt_q   <= '0;
            load_last_q  <= 1'b0;
            load_done_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_a_q <= rsp_data_a_d;
            rsp_data_b_q <= rsp_data_b_d;
`ifdef RAM_PORT_CTRL_BOOTLOAD_EN
            load_cnt_q   <= load_cnt_d;
            load_last_q  <= load_last_d;
            load_done_q  <= load_done_d;
`endif
        end
    end

endmodule
